// File: rtl/axi_slice_dc_isolate_ctrl.sv
// rtl/axi_slice_dc_isolate_ctrl.sv - quiesces the slave AXI port before asserting the slice isolate input
// Optional drain timeout enabled by defining AXI_ISO_TIMEOUT_EN.
module axi_slice_dc_isolate_ctrl #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          isolate_req_i,
  output logic          isolate_o,
  output logic          isolate_ack_o,
  output logic          drain_busy_o,
  input  logic          s_aw_valid_i,
  output logic          s_aw_ready_o,
  output logic          m_aw_valid_o,
  input  logic          m_aw_ready_i,
  input  logic          s_ar_valid_i,
  output logic          s_ar_ready_o,
  output logic          m_ar_valid_o,
  input  logic          m_ar_ready_i,
  input  logic          w_valid_i,
  input  logic          w_ready_i,
  input  logic          w_last_i,
  input  logic          r_valid_i,
  input  logic          r_ready_i,
  input  logic          r_last_i,
  input  logic          b_valid_i,
  input  logic          b_ready_i,
  output logic [CW-1:0] wr_outstanding_o,
  output logic [CW-1:0] rd_outstanding_o
`ifdef AXI_ISO_TIMEOUT_EN
  ,
  output logic          timeout_o
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_e;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  state_e              state_q;
  logic                iso_q, busy_q;
  logic [CW-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic signed [CW:0]  w_pend_q, w_pend_d;
  logic                aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
  logic                aw_open, ar_open, drained;

  // In DRAIN, AW stays open only to admit addresses for W data that already went ahead.
  assign aw_open = (wr_cnt_q < MAX_CNT) &&
                   ((state_q == RUN) || (state_q == DRAIN && w_pend_q[CW]));
  assign ar_open = (state_q == RUN) && (rd_cnt_q < MAX_CNT);

  assign m_aw_valid_o = s_aw_valid_i & aw_open;
  assign s_aw_ready_o = m_aw_ready_i & aw_open;
  assign m_ar_valid_o = s_ar_valid_i & ar_open;
  assign s_ar_ready_o = m_ar_ready_i & ar_open;

  assign aw_hs     = m_aw_valid_o & m_aw_ready_i;
  assign ar_hs     = m_ar_valid_o & m_ar_ready_i;
  assign w_last_hs = w_valid_i & w_ready_i & w_last_i;
  assign b_hs      = b_valid_i & b_ready_i;
  assign r_last_hs = r_valid_i & r_ready_i & r_last_i;

  assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_pend_q == '0);

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    w_pend_d = w_pend_q;
    if (state_q != ISOLATED) begin
      if (aw_hs && !b_hs)                         wr_cnt_d = wr_cnt_q + CW'(1);
      else if (b_hs && !aw_hs && wr_cnt_q != '0)  wr_cnt_d = wr_cnt_q - CW'(1);
      if (ar_hs && !r_last_hs)                    rd_cnt_d = rd_cnt_q + CW'(1);
      else if (r_last_hs && !ar_hs && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - CW'(1);
      if (aw_hs && !w_last_hs)                    w_pend_d = w_pend_q + (CW+1)'(1);
      else if (w_last_hs && !aw_hs)               w_pend_d = w_pend_q - (CW+1)'(1);
    end
  end

`ifdef AXI_ISO_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] timer_q;
  logic          timeout_q;
  assign timeout_o = timeout_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      iso_q    <= 1'b0;
      busy_q   <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      w_pend_q <= '0;
`ifdef AXI_ISO_TIMEOUT_EN
      timer_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      w_pend_q <= w_pend_d;
      case (state_q)
        RUN: if (isolate_req_i) begin
          state_q <= DRAIN;
          busy_q  <= 1'b1;
`ifdef AXI_ISO_TIMEOUT_EN
          timer_q <= '0;
`endif
        end
        DRAIN: if (!isolate_req_i) begin
          state_q <= RUN;
          busy_q  <= 1'b0;
`ifdef AXI_ISO_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end else if (drained) begin
          state_q <= ISOLATED;
          iso_q   <= 1'b1;
          busy_q  <= 1'b0;
`ifdef AXI_ISO_TIMEOUT_EN
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Forced isolation abandons whatever was in flight.
          state_q   <= ISOLATED;
          iso_q     <= 1'b1;
          busy_q    <= 1'b0;
          timeout_q <= 1'b1;
          wr_cnt_q  <= '0;
          rd_cnt_q  <= '0;
          w_pend_q  <= '0;
        end else begin
          timer_q <= timer_q + TW'(1);
`endif
        end
        ISOLATED: if (!isolate_req_i) begin
          state_q <= RUN;
          iso_q   <= 1'b0;
`ifdef AXI_ISO_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= RUN;
          iso_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign isolate_o        = iso_q;
  assign isolate_ack_o    = iso_q;
  assign drain_busy_o     = busy_q;
  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;

`ifndef SYNTHESIS
  a_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (b_hs && !aw_hs && state_q != ISOLATED) |-> (wr_cnt_q != '0));
  a_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_last_hs && !ar_hs && state_q != ISOLATED) |-> (rd_cnt_q != '0));
`endif

endmodule

// File: tb/tb_axi_slice_dc_isolate_ctrl.sv
// tb/tb_axi_slice_dc_isolate_ctrl.sv - self-checking bench for axi_slice_dc_isolate_ctrl
// Build with AXI_ISO_TIMEOUT_EN defined to also cover the drain timeout.
module tb_axi_slice_dc_isolate_ctrl;
  localparam int MAXO = 4;
  localparam int TOC  = 16;
  localparam int CW   = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic rst, req;
  logic s_aw_valid, m_aw_ready, s_ar_valid, m_ar_ready;
  logic w_valid, w_ready, w_last, r_valid, r_ready, r_last, b_valid, b_ready;
  logic isolate_o, isolate_ack_o, drain_busy_o;
  logic s_aw_ready_o, m_aw_valid_o, s_ar_ready_o, m_ar_valid_o;
  logic [CW-1:0] wr_o, rd_o;
`ifdef AXI_ISO_TIMEOUT_EN
  logic timeout_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  // Reference model: phase 0=running, 1=draining, 2=isolated
  int m_ph, m_wr, m_rd, m_wp, m_tmr;
  bit m_to;

  always #5 clk = ~clk;

  axi_slice_dc_isolate_ctrl #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TOC)) dut (
    .clk_i(clk), .rst_i(rst), .isolate_req_i(req),
    .isolate_o(isolate_o), .isolate_ack_o(isolate_ack_o), .drain_busy_o(drain_busy_o),
    .s_aw_valid_i(s_aw_valid), .s_aw_ready_o(s_aw_ready_o),
    .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready),
    .s_ar_valid_i(s_ar_valid), .s_ar_ready_o(s_ar_ready_o),
    .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready),
    .w_valid_i(w_valid), .w_ready_i(w_ready), .w_last_i(w_last),
    .r_valid_i(r_valid), .r_ready_i(r_ready), .r_last_i(r_last),
    .b_valid_i(b_valid), .b_ready_i(b_ready),
    .wr_outstanding_o(wr_o), .rd_outstanding_o(rd_o)
`ifdef AXI_ISO_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  function automatic bit aw_ok();
    return (m_wr < MAXO) && (m_ph == 0 || (m_ph == 1 && m_wp < 0));
  endfunction

  function automatic bit ar_ok();
    return (m_ph == 0) && (m_rd < MAXO);
  endfunction

  task automatic idle();
    {s_aw_valid, m_aw_ready, s_ar_valid, m_ar_ready} = '0;
    {w_valid, w_ready, w_last, r_valid, r_ready, r_last, b_valid, b_ready} = '0;
  endtask

  // Advance the model by one clock from the inputs currently driven, then cross the edge.
  task automatic tick();
    int aw, ar, wl, b, r, nph;
    aw = int'(s_aw_valid && m_aw_ready && aw_ok());
    ar = int'(s_ar_valid && m_ar_ready && ar_ok());
    wl = int'(w_valid && w_ready && w_last);
    b  = int'(b_valid && b_ready);
    r  = int'(r_valid && r_ready && r_last);
    if (rst) begin
      m_ph = 0; m_wr = 0; m_rd = 0; m_wp = 0; m_tmr = 0; m_to = 0;
    end else begin
      nph = m_ph;
      if (m_ph == 0 && req) begin nph = 1; m_tmr = 0; end
      else if (m_ph == 1 && !req) begin nph = 0; m_to = 0; end
      else if (m_ph == 1 && m_wr == 0 && m_rd == 0 && m_wp == 0) nph = 2;
      else if (m_ph == 2 && !req) begin nph = 0; m_to = 0; end
      if (m_ph != 2) begin
        m_wr = m_wr + aw - b;  if (m_wr < 0) m_wr = 0;
        m_rd = m_rd + ar - r;  if (m_rd < 0) m_rd = 0;
        m_wp = m_wp + aw - wl;
      end
`ifdef AXI_ISO_TIMEOUT_EN
      if (m_ph == 1 && nph == 1) begin
        if (m_tmr == TOC - 1) begin
          nph = 2; m_to = 1; m_wr = 0; m_rd = 0; m_wp = 0;
        end else m_tmr++;
      end
`endif
      m_ph = nph;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {s_aw_valid, m_aw_ready, s_ar_valid, m_ar_ready} = 4'($urandom);
      tick();
    end
    req = 1'b0;
    n_vec++; if (isolate_o !== 1'b0)    begin n_err++; $display("FAIL reset_isolate: got %b want 0", isolate_o); end
    n_vec++; if (isolate_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", isolate_ack_o); end
    n_vec++; if (drain_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", drain_busy_o); end
    n_vec++; if (wr_o !== '0 || rd_o !== '0) begin n_err++; $display("FAIL reset_counts: got wr=%0d rd=%0d want 0 0", wr_o, rd_o); end
    n_vec++; if ({m_aw_valid_o, s_aw_ready_o, m_ar_valid_o, s_ar_ready_o} !== {s_aw_valid, m_aw_ready, s_ar_valid, m_ar_ready})
      begin n_err++; $display("FAIL reset_passthru: got %b want %b", {m_aw_valid_o, s_aw_ready_o, m_ar_valid_o, s_ar_ready_o}, {s_aw_valid, m_aw_ready, s_ar_valid, m_ar_ready}); end
`ifdef AXI_ISO_TIMEOUT_EN
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
`endif
    rst = 1'b0; idle(); tick();
  endtask

  task automatic test_idle_isolate();
    idle(); m_aw_ready = 1'b1; m_ar_ready = 1'b1; req = 1'b1; #1;
    n_vec++; if (s_aw_ready_o !== 1'b1 || isolate_o !== 1'b0) begin n_err++; $display("FAIL idle_c0: got awr=%b iso=%b want 1 0", s_aw_ready_o, isolate_o); end
    tick();
    n_vec++; if ({drain_busy_o, s_aw_ready_o, s_ar_ready_o, isolate_o} !== 4'b1000) begin n_err++; $display("FAIL idle_c1: got busy/awr/arr/iso=%b want 1000", {drain_busy_o, s_aw_ready_o, s_ar_ready_o, isolate_o}); end
    tick();
    n_vec++; if ({isolate_o, isolate_ack_o, drain_busy_o} !== 3'b110) begin n_err++; $display("FAIL idle_c2: got iso/ack/busy=%b want 110", {isolate_o, isolate_ack_o, drain_busy_o}); end
    req = 1'b0; tick();
    n_vec++; if ({isolate_o, s_aw_ready_o, s_ar_ready_o} !== 3'b011) begin n_err++; $display("FAIL idle_release: got iso/awr/arr=%b want 011", {isolate_o, s_aw_ready_o, s_ar_ready_o}); end
    idle();
  endtask

  task automatic test_drain_latency();
    idle(); s_aw_valid = 1'b1; m_aw_ready = 1'b1; w_valid = 1'b1; w_ready = 1'b1; w_last = 1'b1;
    repeat (3) tick();
    idle(); s_ar_valid = 1'b1; m_ar_ready = 1'b1;
    repeat (2) tick();
    idle(); #1;
    n_vec++; if (wr_o !== CW'(3) || rd_o !== CW'(2)) begin n_err++; $display("FAIL drain_counts: got wr=%0d rd=%0d want 3 2", wr_o, rd_o); end
    req = 1'b1; tick();
    m_aw_ready = 1'b1; s_aw_valid = 1'b1;
    repeat (3) begin
      #1;
      n_vec++; if (isolate_o !== 1'b0 || s_aw_ready_o !== 1'b0) begin n_err++; $display("FAIL drain_wait: got iso=%b awr=%b want 0 0", isolate_o, s_aw_ready_o); end
      tick();
    end
    idle(); b_valid = 1'b1; b_ready = 1'b1;
    repeat (3) tick();
    idle(); r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
    tick();
    #1;
    n_vec++; if (isolate_o !== 1'b0) begin n_err++; $display("FAIL drain_early: got iso=%b want 0", isolate_o); end
    tick();
    idle(); #1;
    n_vec++; if (isolate_o !== 1'b0 || rd_o !== '0) begin n_err++; $display("FAIL drain_n1: got iso=%b rd=%0d want 0 0", isolate_o, rd_o); end
    tick();
    n_vec++; if (isolate_o !== 1'b1) begin n_err++; $display("FAIL drain_n2: got iso=%b want 1", isolate_o); end
    req = 1'b0; tick();
  endtask

  task automatic test_w_leads_aw();
    idle(); w_valid = 1'b1; w_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin w_last = (i == 3); tick(); end
    idle(); m_aw_ready = 1'b1; m_ar_ready = 1'b1; req = 1'b1; tick();
    n_vec++; if ({drain_busy_o, s_aw_ready_o, s_ar_ready_o} !== 3'b110) begin n_err++; $display("FAIL wlead_open: got busy/awr/arr=%b want 110", {drain_busy_o, s_aw_ready_o, s_ar_ready_o}); end
    s_aw_valid = 1'b1; #1;
    n_vec++; if (m_aw_valid_o !== 1'b1) begin n_err++; $display("FAIL wlead_fwd: got %b want 1", m_aw_valid_o); end
    tick();
    n_vec++; if (s_aw_ready_o !== 1'b0 || wr_o !== CW'(1)) begin n_err++; $display("FAIL wlead_closed: got awr=%b wr=%0d want 0 1", s_aw_ready_o, wr_o); end
    idle(); b_valid = 1'b1; b_ready = 1'b1; tick();
    idle(); #1;
    n_vec++; if (isolate_o !== 1'b0 || wr_o !== '0) begin n_err++; $display("FAIL wlead_n1: got iso=%b wr=%0d want 0 0", isolate_o, wr_o); end
    tick();
    n_vec++; if (isolate_o !== 1'b1) begin n_err++; $display("FAIL wlead_iso: got %b want 1", isolate_o); end
    req = 1'b0; tick();
  endtask

  task automatic test_saturation();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    s_aw_valid = 1'b1; m_aw_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (s_aw_ready_o !== (i < MAXO)) begin n_err++; $display("FAIL sat_ready%0d: got %b want %b", i, s_aw_ready_o, i < MAXO); end
      tick();
      n_vec++; if (int'(wr_o) > MAXO) begin n_err++; $display("FAIL sat_bound%0d: got %0d want <=%0d", i, wr_o, MAXO); end
    end
    b_valid = 1'b1; b_ready = 1'b1; #1;
    n_vec++; if (s_aw_ready_o !== 1'b0) begin n_err++; $display("FAIL sat_bcycle: got %b want 0", s_aw_ready_o); end
    tick();
    b_valid = 1'b0; #1;
    n_vec++; if (s_aw_ready_o !== 1'b1 || wr_o !== CW'(MAXO - 1)) begin n_err++; $display("FAIL sat_reopen: got awr=%b wr=%0d want 1 %0d", s_aw_ready_o, wr_o, MAXO - 1); end
    tick();
    n_vec++; if (wr_o !== CW'(MAXO) || s_aw_ready_o !== 1'b0) begin n_err++; $display("FAIL sat_refill: got wr=%0d awr=%b want %0d 0", wr_o, s_aw_ready_o, MAXO); end
    rst = 1'b1; idle(); tick(); rst = 1'b0;
  endtask

  task automatic test_abort_and_reset();
    idle(); s_ar_valid = 1'b1; m_ar_ready = 1'b1;
    repeat (2) tick();
    s_ar_valid = 1'b0; req = 1'b1; tick(); tick();
    n_vec++; if (drain_busy_o !== 1'b1 || s_ar_ready_o !== 1'b0 || rd_o !== CW'(2)) begin n_err++; $display("FAIL abort_drain: got busy=%b arr=%b rd=%0d want 1 0 2", drain_busy_o, s_ar_ready_o, rd_o); end
    req = 1'b0; tick();
    n_vec++; if (drain_busy_o !== 1'b0 || s_ar_ready_o !== 1'b1 || rd_o !== CW'(2)) begin n_err++; $display("FAIL abort_run: got busy=%b arr=%b rd=%0d want 0 1 2", drain_busy_o, s_ar_ready_o, rd_o); end
    req = 1'b1; tick(); tick();
    rst = 1'b1; m_aw_ready = 1'b1; tick();
    n_vec++; if ({drain_busy_o, isolate_o, s_aw_ready_o, s_ar_ready_o} !== 4'b0011 || rd_o !== '0 || wr_o !== '0)
      begin n_err++; $display("FAIL abort_reset: got busy/iso/awr/arr=%b rd=%0d wr=%0d want 0011 0 0", {drain_busy_o, isolate_o, s_aw_ready_o, s_ar_ready_o}, rd_o, wr_o); end
    rst = 1'b0; req = 1'b0; idle(); tick();
  endtask

`ifdef AXI_ISO_TIMEOUT_EN
  task automatic test_timeout();
    idle(); s_aw_valid = 1'b1; m_aw_ready = 1'b1; w_valid = 1'b1; w_ready = 1'b1; w_last = 1'b1; tick();
    idle(); req = 1'b1; tick();
    for (int k = 0; k < TOC; k++) begin
      n_vec++; if (drain_busy_o !== 1'b1 || timeout_o !== 1'b0) begin n_err++; $display("FAIL to_wait%0d: got busy=%b to=%b want 1 0", k, drain_busy_o, timeout_o); end
      tick();
    end
    n_vec++; if ({isolate_o, timeout_o} !== 2'b11 || wr_o !== '0) begin n_err++; $display("FAIL to_fire: got iso/to=%b wr=%0d want 11 0", {isolate_o, timeout_o}, wr_o); end
    req = 1'b0; tick();
    n_vec++; if ({isolate_o, timeout_o} !== 2'b00) begin n_err++; $display("FAIL to_clear: got iso/to=%b want 00", {isolate_o, timeout_o}); end
  endtask
`endif

  task automatic test_random();
    logic [10:0] got, exp;
    req = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 24) == 0) req = ~req;
      {s_aw_valid, m_aw_ready, s_ar_valid, m_ar_ready} = 4'($urandom);
      {w_valid, w_ready, r_valid, r_ready, b_ready} = 5'($urandom);
      w_last  = $urandom_range(0, 1) && (m_wp > -3);
      r_last  = $urandom_range(0, 1) && (m_rd > 0);
      b_valid = $urandom_range(0, 1) && (m_wr > 0) && (m_wp < m_wr);
      #1;
      got = {isolate_o, isolate_ack_o, drain_busy_o, m_aw_valid_o, s_aw_ready_o, m_ar_valid_o, s_ar_ready_o,
             wr_o == CW'(m_wr), rd_o == CW'(m_rd), 1'b1, 1'b1};
      exp = {m_ph == 2, m_ph == 2, m_ph == 1, s_aw_valid & aw_ok(), m_aw_ready & aw_ok(),
             s_ar_valid & ar_ok(), m_ar_ready & ar_ok(), 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef AXI_ISO_TIMEOUT_EN
      got[0] = timeout_o; exp[0] = m_to;
`endif
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random_c%0d: got %b want %b (wr %0d/%0d rd %0d/%0d)", c, got, exp, wr_o, m_wr, rd_o, m_rd);
      end
      tick();
    end
    idle(); req = 1'b0; tick();
  endtask

  initial begin
    m_ph = 0; m_wr = 0; m_rd = 0; m_wp = 0; m_tmr = 0; m_to = 0;
    rst = 1'b1; req = 1'b0; idle();
    test_reset();
    test_idle_isolate();
    test_drain_latency();
    test_w_leads_aw();
    test_saturation();
    test_abort_and_reset();
`ifdef AXI_ISO_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
